// File: rtl/s2p_packer.sv
`default_nettype none
// ============================================================================
// Module   : s2p_packer
// Brief    : Serial-to-parallel complex sample packer with per-frame vector
//            counting. Optional S2P_BITREV_EN selects bit-reversed lane order.
// Revision : 1.0 - initial release
// ============================================================================
module s2p_packer #(
  parameter int DATA_WIDTH = 9,
  parameter int OUT_SIZE   = 16,
  parameter int FRAME_VECS = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         din_valid,
  input  logic signed [DATA_WIDTH-1:0] din_i,
  input  logic signed [DATA_WIDTH-1:0] din_q,
  input  logic                         frame_start,
  output logic signed [DATA_WIDTH-1:0] dout_i [0:OUT_SIZE-1],
  output logic signed [DATA_WIDTH-1:0] dout_q [0:OUT_SIZE-1],
  output logic                         dout_valid,
  output logic                         frame_done
);

  localparam int c_LANE_W = $clog2(OUT_SIZE);
  localparam int c_VEC_W  = (FRAME_VECS > 1) ? $clog2(FRAME_VECS) : 1;
  localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(OUT_SIZE - 1);
  localparam logic [c_VEC_W-1:0]  c_LAST_VEC  = c_VEC_W'(FRAME_VECS - 1);

  logic [c_LANE_W-1:0]         r_lcnt;
  logic [c_VEC_W-1:0]          r_vcnt;
  logic signed [DATA_WIDTH-1:0] r_buf_i [0:OUT_SIZE-1];
  logic signed [DATA_WIDTH-1:0] r_buf_q [0:OUT_SIZE-1];

  logic [c_LANE_W-1:0]         w_lane;
  logic                        w_complete;
  logic                        w_frame_end;
  logic signed [DATA_WIDTH-1:0] w_next_i [0:OUT_SIZE-1];
  logic signed [DATA_WIDTH-1:0] w_next_q [0:OUT_SIZE-1];

  function automatic logic [c_LANE_W-1:0] f_map(input logic [c_LANE_W-1:0] k);
    logic [c_LANE_W-1:0] r;
    r = k;
`ifdef S2P_BITREV_EN
    for (int b = 0; b < c_LANE_W; b++) begin
      r[b] = k[c_LANE_W-1-b];
    end
`endif
    return r;
  endfunction

  // Buffer image including the current sample, so a completing vector can be
  // copied to the output in the same cycle its last sample arrives.
  always_comb begin
    w_lane      = frame_start ? f_map('0) : f_map(r_lcnt);
    w_complete  = din_valid && !frame_start && (r_lcnt == c_LAST_LANE);
    w_frame_end = (r_vcnt == c_LAST_VEC);
    for (int k = 0; k < OUT_SIZE; k++) begin
      w_next_i[k] = r_buf_i[k];
      w_next_q[k] = r_buf_q[k];
    end
    w_next_i[w_lane] = din_i;
    w_next_q[w_lane] = din_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lcnt     <= '0;
      r_vcnt     <= '0;
      r_buf_i    <= '{default: '0};
      r_buf_q    <= '{default: '0};
      dout_i     <= '{default: '0};
      dout_q     <= '{default: '0};
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
      if (din_valid) begin
        r_buf_i <= w_next_i;
        r_buf_q <= w_next_q;
        if (frame_start) begin
          r_lcnt <= c_LANE_W'(1);
          r_vcnt <= '0;
        end else if (w_complete) begin
          r_lcnt     <= '0;
          dout_i     <= w_next_i;
          dout_q     <= w_next_q;
          dout_valid <= 1'b1;
          frame_done <= w_frame_end;
          r_vcnt     <= w_frame_end ? '0 : r_vcnt + 1'b1;
        end else begin
          r_lcnt <= r_lcnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/s2p_packer.md
# s2p_packer

Serial-to-parallel packer at the FFT front end. Collects one complex sample per valid cycle and assembles OUT_SIZE samples into a parallel vector. Presents each completed vector with a single-cycle `dout_valid` strobe, which drives the `din_valid`/`din_i`/`din_q` input of the stage delay buffer. Counts vectors per FFT frame and flags the last vector of each frame.

## Interface

Parameters:
- `DATA_WIDTH`, 9: signed sample width, I and Q each.
- `OUT_SIZE`, 16: samples per output vector; power of two, at least 2.
- `FRAME_VECS`, 32: vectors per FFT frame; at least 1.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `rstn`  in  1: synchronous active-low reset, sampled on posedge `clk`.
- `din_valid`  in  1: serial sample qualifier.
- `din_i`  in  signed DATA_WIDTH: serial in-phase sample.
- `din_q`  in  signed DATA_WIDTH: serial quadrature sample.
- `frame_start`  in  1: marks the current `din_valid` sample as sample 0 of a new frame; ignored when `din_valid`=0.
- `dout_i`  out  signed DATA_WIDTH [0:OUT_SIZE-1]: packed in-phase vector, registered.
- `dout_q`  out  signed DATA_WIDTH [0:OUT_SIZE-1]: packed quadrature vector, registered.
- `dout_valid`  out  1: one-cycle strobe per completed vector.
- `frame_done`  out  1: one-cycle strobe, coincident with `dout_valid`, for vector FRAME_VECS-1 of a frame.

## Operation

- Internal state:
  - Pack buffer: OUT_SIZE x (I,Q).
  - Lane counter `lcnt`: 0..OUT_SIZE-1.
  - Vector counter `vcnt`: 0..FRAME_VECS-1.
  - Output register pair.
- Cycle with `din_valid`=1 and `frame_start`=0:
  - Write the sample into pack-buffer lane `map(lcnt)`.
  - If `lcnt` < OUT_SIZE-1, increment `lcnt`.
  - If `lcnt` = OUT_SIZE-1:
    - Copy the pack buffer, including the current sample, to the output registers.
    - Set `lcnt` to 0.
    - Assert `dout_valid` the next cycle.
    - If `vcnt` = FRAME_VECS-1, also assert `frame_done` and wrap `vcnt` to 0. Otherwise increment `vcnt`.
- Cycle with `din_valid`=1 and `frame_start`=1:
  - Discard any partial vector.
  - Write the sample into lane `map(0)` and set `lcnt` to 1.
  - Set `vcnt` to 0.
  - No output is emitted for the discarded partial vector.
  - If OUT_SIZE would be reached by this sample, no vector is emitted; not possible for OUT_SIZE at least 2.
- Cycle with `din_valid`=0: hold all state. Gaps of any length between samples are legal and do not affect packing.
- Output registers hold their last vector until the next completion. `dout_*` are meaningful only when `dout_valid`=1.
- No backpressure: the downstream stage accepts every strobe. Back-to-back vectors are legal, at most one every OUT_SIZE valid cycles.
- Sample values pass through unmodified, sign preserved, with no arithmetic.
- Pack-buffer lanes not yet written in a vector keep stale data. This is irrelevant because `dout_valid` only fires after all OUT_SIZE lanes are written.

## Timing

- Reset (`rstn`=0 at posedge) forces the following:
  - `lcnt`=0, `vcnt`=0.
  - `dout_valid`=0, `frame_done`=0.
  - All `dout_i`/`dout_q` lanes = 0.
  - Pack buffer = 0.
- Reset mid-vector or mid-frame discards all partial data. The first valid sample after reset is lane 0 of vector 0.
- Latency: the last sample of a vector is taken at edge N. `dout_valid` and the new `dout_*` are visible after edge N, for one cycle.
- `dout_valid` is never high two consecutive cycles for OUT_SIZE at least 2.
- `frame_done` is never high without `dout_valid`.
- Reset has priority over `din_valid` and `frame_start` in the same cycle.

## Configuration

- Macro `S2P_BITREV_EN`.
- Defined: `map(k)` = bit-reverse of `k` over log2(OUT_SIZE) bits. Each output vector is in bit-reversed lane order for the radix-2 input stage.
- Undefined: `map(k)` = `k`, natural order.
- All timing, counters and strobes are identical in both builds.

## Test plan

- Reset, then 16 consecutive valid samples with I=1..16 and Q=-1..-16 (default params, macro off). Required response, the cycle after the 16th sample:
  - `dout_valid`=1, `dout_i[j]`=j+1, `dout_q[j]`=-(j+1).
  - `dout_valid`=0 on all other cycles.
- Same 16 samples with random 0-3 cycle gaps -> identical vector. `dout_valid` asserts exactly one cycle after the 16th valid sample.
- 512 continuous samples (32 vectors) -> 32 `dout_valid` strobes. `frame_done`=1 only with the 32nd strobe. The 513th-528th samples start a new frame, so `frame_done` recurs after a further 32 vectors.
- Sequence: 5 samples, then `frame_start` with I=100, then 15 more samples I=101..115. Required response:
  - Exactly one vector, with `dout_i[0]`=100 and `dout_i[15]`=115.
  - The first 5 samples never appear on the output.
  - `vcnt` restarts, so `frame_done` comes 31 vectors after this one.
- `rstn` low for one cycle after 9 samples. Required response:
  - All outputs 0 the next cycle.
  - The next 16 samples form vector 0 with lane 0 = the first post-reset sample.
- Build with `S2P_BITREV_EN` defined, samples I=0..15. Required response: `dout_i[1]`=8, `dout_i[8]`=1, `dout_i[3]`=12, `dout_i[15]`=15.
